reg_file_write_arbiter: RTL and testbench

//   Owns the single write port (addr_3/write_data/write_enable) of reg_file.

---
 rtl/reg_file_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_reg_file_write_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_write_arbiter.sv
// Write-port owner for reg_file: zero-fills all registers after reset, then arbitrates wb0/wb1 writes.
// Optional macro RF_FWD_EN adds combinational forwarding of the pending write to both read ports.
module reg_file_write_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CLEAR_EN     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_addr_3,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              init_done
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0]   ZERO_ADDR  = {ADDR_W{1'b0}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE   = (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
  localparam logic   RESET_INIT_DN = (CLEAR_EN != 0) ? 1'b0 : 1'b1;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [STARVE_W-1:0] starve_r;
  logic                grant0_s;
  logic                grant1_s;
  logic                force1_s;
  logic                init_done_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and grant selection; a starved wb1 overrides wb0 priority.
  always_comb begin
    state_nxt_s = state_r;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    force1_s    = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        force1_s = (starve_r == STARVE_MAX) && wb1_valid;
        if (force1_s) begin
          grant1_s = 1'b1;
        end else if (wb0_valid) begin
          grant0_s = 1'b1;
        end else if (wb1_valid) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  assign wb0_ready = grant0_s;
  assign wb1_ready = grant1_s;

  // Write-port register: clear sweep, then one accepted request per cycle; x0 writes are swallowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_enable <= 1'b0;
      rf_addr_3       <= ZERO_ADDR;
      rf_write_data   <= {DATA_W{1'b0}};
      clr_cnt_r       <= ZERO_ADDR;
    end else if (state_r == ST_CLEAR) begin
      rf_write_enable <= 1'b1;
      rf_addr_3       <= clr_cnt_r;
      rf_write_data   <= {DATA_W{1'b0}};
      clr_cnt_r       <= clr_cnt_r + 1'b1;
    end else if (grant0_s) begin
      rf_write_enable <= (wb0_addr != ZERO_ADDR);
      rf_addr_3       <= wb0_addr;
      rf_write_data   <= wb0_data;
      clr_cnt_r       <= clr_cnt_r;
    end else if (grant1_s) begin
      rf_write_enable <= (wb1_addr != ZERO_ADDR);
      rf_addr_3       <= wb1_addr;
      rf_write_data   <= wb1_data;
      clr_cnt_r       <= clr_cnt_r;
    end else begin
      rf_write_enable <= 1'b0;
      rf_addr_3       <= rf_addr_3;
      rf_write_data   <= rf_write_data;
      clr_cnt_r       <= clr_cnt_r;
    end
  end

  // Consecutive wb1 denials, saturating at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (!wb1_valid || grant1_s) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (starve_r != STARVE_MAX) begin
      starve_r <= starve_r + 1'b1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // init_done rises on the same edge that loads the last clear address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done_r <= RESET_INIT_DN;
    end else begin
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  assign init_done = init_done_r;

`ifdef RF_FWD_EN
  // Bypass the write that reg_file has not yet absorbed.
  always_comb begin
    read_data_1 = rf_read_data_1;
    read_data_2 = rf_read_data_2;
    if (rf_write_enable && (rf_addr_3 == rd_addr_1) && (rd_addr_1 != ZERO_ADDR)) begin
      read_data_1 = rf_write_data;
    end else begin
      read_data_1 = rf_read_data_1;
    end
    if (rf_write_enable && (rf_addr_3 == rd_addr_2) && (rd_addr_2 != ZERO_ADDR)) begin
      read_data_2 = rf_write_data;
    end else begin
      read_data_2 = rf_read_data_2;
    end
  end
`else
  logic unused_rd_addr_s;
  assign unused_rd_addr_s = ^{rd_addr_1, rd_addr_2};
  assign read_data_1 = rf_read_data_1;
  assign read_data_2 = rf_read_data_2;
`endif

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Bench for reg_file_write_arbiter: models reg_file and the arbiter's externally visible rules,
// compares every negedge, and adds directed literal checks.
module tb_reg_file_write_arbiter;
  localparam int NREG = 32;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [4:0]  wb0_addr = 5'd0, wb1_addr = 5'd0;
  logic [31:0] wb0_data = 32'd0, wb1_data = 32'd0;
  logic        wb0_ready, wb1_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_3;
  logic [31:0] rf_write_data;
  logic [4:0]  rd_addr_1 = 5'd0, rd_addr_2 = 5'd0;
  logic [31:0] rf_read_data_1, rf_read_data_2;
  logic [31:0] read_data_1, read_data_2;
  logic        init_done;

  logic [31:0] mem [NREG];
  int total = 0;
  int bad = 0;

  // model state: registers cleared so far, current wb1 denial run, pending write
  int          m_cleared;
  int          m_denied;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  reg_file_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_write_enable(rf_write_enable), .rf_addr_3(rf_addr_3), .rf_write_data(rf_write_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // reg_file itself: no reset, synchronous write, asynchronous read
  always @(posedge clk) if (rf_write_enable) mem[rf_addr_3] <= rf_write_data;
  assign rf_read_data_1 = mem[rd_addr_1];
  assign rf_read_data_2 = mem[rd_addr_2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit running();
    return m_cleared == NREG;
  endfunction

  function automatic bit exp_g1();
    return running() && wb1_valid && (m_denied == SLIM || !wb0_valid);
  endfunction

  function automatic bit exp_g0();
    return running() && wb0_valid && !(m_denied == SLIM && wb1_valid);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef RF_FWD_EN
    if (m_we && m_addr == a && a != 5'd0) return m_data;
`endif
    return mem[a];
  endfunction

  // behavioural model of the write port
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cleared <= 0; m_denied <= 0;
      m_we <= 1'b0; m_addr <= 5'd0; m_data <= 32'd0;
    end else begin
      if (!running()) begin
        m_we <= 1'b1; m_addr <= 5'(m_cleared); m_data <= 32'd0;
        m_cleared <= m_cleared + 1;
      end else if (exp_g0()) begin
        m_we <= (wb0_addr != 5'd0); m_addr <= wb0_addr; m_data <= wb0_data;
      end else if (exp_g1()) begin
        m_we <= (wb1_addr != 5'd0); m_addr <= wb1_addr; m_data <= wb1_data;
      end else begin
        m_we <= 1'b0;
      end
      if (!wb1_valid || exp_g1()) m_denied <= 0;
      else if (m_denied < SLIM) m_denied <= m_denied + 1;
    end
  end

  // compare process
  always @(negedge clk) begin
    check("wb0_ready", {31'd0, wb0_ready}, {31'd0, exp_g0()});
    check("wb1_ready", {31'd0, wb1_ready}, {31'd0, exp_g1()});
    check("rf_we", {31'd0, rf_write_enable}, {31'd0, m_we});
    check("rf_addr", {27'd0, rf_addr_3}, {27'd0, m_addr});
    check("rf_data", rf_write_data, m_data);
    check("init_done", {31'd0, init_done}, {31'd0, running()});
    check("read_data_1", read_data_1, exp_rd(rd_addr_1));
    check("read_data_2", read_data_2, exp_rd(rd_addr_2));
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    int seen;
    for (int i = 0; i < NREG; i++) mem[i] = $urandom;
    drive_edge();
    drive_edge();
    #1;
    check("reset_we", {31'd0, rf_write_enable}, 32'd0);
    check("reset_init_done", {31'd0, init_done}, 32'd0);
    reset_n = 1'b1;

    // 1: zero-fill sweep
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rf_write_enable) begin
        check("clr_addr", {27'd0, rf_addr_3}, n);
        check("clr_data", rf_write_data, 32'd0);
        check("clr_init_done", {31'd0, init_done}, (n == 31) ? 32'd1 : 32'd0);
        n++;
      end
    end
    check("clr_cycles", n, 32'd32);
    for (int i = 0; i < NREG; i++) begin
      drive_edge();
      rd_addr_1 = 5'(i);
      @(negedge clk);
      check("clr_read", read_data_1, 32'd0);
    end

    // 2: single wb0 write to x5
    drive_edge();
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t2_ready", {31'd0, wb0_ready}, 32'd1);
    drive_edge();
    wb0_valid = 1'b0; rd_addr_1 = 5'd5;
    @(negedge clk);
    check("t2_we", {31'd0, rf_write_enable}, 32'd1);
    check("t2_addr", {27'd0, rf_addr_3}, 32'd5);
    check("t2_data", rf_write_data, 32'hDEADBEEF);
`ifdef RF_FWD_EN
    check("t2_read_fwd", read_data_1, 32'hDEADBEEF);
`else
    check("t2_read_old", read_data_1, 32'd0);
`endif
    @(negedge clk);
    check("t2_read_new", read_data_1, 32'hDEADBEEF);

    // 3: both requesters saturated
    drive_edge();
    wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h0000_1010;
    wb1_valid = 1'b1; wb1_addr = 5'd11; wb1_data = 32'h0000_1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_wb1_grant", {31'd0, wb1_ready}, (i % 5 == 4) ? 32'd1 : 32'd0);
      check("t3_wb0_grant", {31'd0, wb0_ready}, (i % 5 == 4) ? 32'd0 : 32'd1);
    end
    drive_edge();
    wb0_valid = 1'b0; wb1_valid = 1'b0;

    // 4: x0 write accepted then dropped
    drive_edge();
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h0000_1234;
    @(negedge clk);
    check("t4_ready", {31'd0, wb1_ready}, 32'd1);
    drive_edge();
    wb1_valid = 1'b0; rd_addr_1 = 5'd0;
    @(negedge clk);
    check("t4_we", {31'd0, rf_write_enable}, 32'd0);
    check("t4_read_x0", read_data_1, 32'd0);

    // 6: read-during-write of x7 on port 2
    drive_edge();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'hA5A5A5A5; rd_addr_2 = 5'd7;
    @(negedge clk);
    drive_edge();
    wb0_valid = 1'b0;
    @(negedge clk);
`ifdef RF_FWD_EN
    check("t6_read_fwd", read_data_2, 32'hA5A5A5A5);
`else
    check("t6_read_old", read_data_2, 32'd0);
`endif
    @(negedge clk);
    check("t6_read_new", read_data_2, 32'hA5A5A5A5);

    // 5: reset with an uncommitted write to x9
    drive_edge();
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h0000_0055; rd_addr_1 = 5'd9;
    @(negedge clk);
    check("t5_ready", {31'd0, wb0_ready}, 32'd1);
    drive_edge();
    check("t5_pending_we", {31'd0, rf_write_enable}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_we", {31'd0, rf_write_enable}, 32'd0);
    check("t5_rst_addr", {27'd0, rf_addr_3}, 32'd0);
    check("t5_rst_data", rf_write_data, 32'd0);
    check("t5_rst_init", {31'd0, init_done}, 32'd0);
    check("t5_rst_ready", {31'd0, wb0_ready}, 32'd0);
    wb0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_x9_not_written", read_data_1, 32'd0);
    drive_edge();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (rf_write_enable) begin
        check("t5_restart_addr", {27'd0, rf_addr_3}, 32'd0);
        seen = 1;
      end
    end
    check("t5_restart_seen", seen, 32'd1);
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("t5_init_again", {31'd0, init_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
